// File: rtl/sseg_scan_if.sv
// Producer-side handshake bundle for the 4-digit scan controller.
// Carries digit loads toward the display and busy/ack status back.
interface sseg_scan_if;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        busy;
   logic        load_ack;

   modport master (
      output load, digits_in, dp_in, blank_lz,
      input  busy, load_ack
   );

   modport slave (
      input  load, digits_in, dp_in, blank_lz,
      output busy, load_ack
   );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Fixed-schedule 4-digit 7-segment scanner with per-slot blanking,
// double-buffered loads handed off on frame boundaries, and zero blanking.
module sseg_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   sseg_scan_if.slave bus,
   output logic [6:0] sseg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   pend_dig_q, pend_dig_d;
   logic [3:0]    pend_dp_q, pend_dp_d;
   logic          pend_lz_q, pend_lz_d;
   logic          pend_vld_q, pend_vld_d;
   logic [15:0]   act_dig_q, act_dig_d;
   logic [3:0]    act_dp_q, act_dp_d;
   logic          act_lz_q, act_lz_d;
   logic          ack_q, ack_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    sseg_q, sseg_d;
   logic          dp_q, dp_d;

   logic          last, frame, xfer, in_blank;
   logic [3:0]    zero, lz_m, cur;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'h0:    dec = 7'b1000000;
         4'h1:    dec = 7'b1111001;
         4'h2:    dec = 7'b0100100;
         4'h3:    dec = 7'b0110000;
         4'h4:    dec = 7'b0011001;
         4'h5:    dec = 7'b0010010;
         4'h6:    dec = 7'b0000010;
         4'h7:    dec = 7'b1111000;
         4'h8:    dec = 7'b0000000;
         4'h9:    dec = 7'b0010000;
         4'hA:    dec = 7'b0001000;
         4'hB:    dec = 7'b0000011;
         4'hC:    dec = 7'b1000110;
         4'hD:    dec = 7'b0100001;
         4'hE:    dec = 7'b0000110;
         default: dec = 7'b0001110;
      endcase
   endfunction

   // Blank window at the head of every slot; absent when BLANK_CYC is 0.
   if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
   end else begin : g_blank
      localparam logic [CW-1:0] BLK = CW'(BLANK_CYC);
      assign in_blank = (cnt_q < BLK);
   end

   // Slot scheduling, buffer handoff and next pin values.
   always_comb begin
      last  = (cnt_q == LAST);
      frame = last && (idx_q == 2'd3);
      xfer  = frame && pend_vld_q;

      cnt_d = last ? '0 : cnt_q + 1'b1;
      idx_d = last ? idx_q + 2'd1 : idx_q;

      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_lz_d  = pend_lz_q;
      pend_vld_d = pend_vld_q;
      if (xfer) pend_vld_d = 1'b0;
      if (bus.load) begin
         pend_dig_d = bus.digits_in;
         pend_dp_d  = bus.dp_in;
         pend_lz_d  = bus.blank_lz;
         pend_vld_d = 1'b1;
      end

      act_dig_d = act_dig_q;
      act_dp_d  = act_dp_q;
      act_lz_d  = act_lz_q;
      if (xfer) begin
         act_dig_d = pend_dig_q;
         act_dp_d  = pend_dp_q;
         act_lz_d  = pend_lz_q;
      end
      ack_d = xfer;

      for (int i = 0; i < 4; i++) zero[i] = (act_dig_q[4*i +: 4] == 4'h0);
      lz_m[3] = act_lz_q & zero[3];
      lz_m[2] = lz_m[3] & zero[2];
      lz_m[1] = lz_m[2] & zero[1];
      lz_m[0] = 1'b0;
      cur = act_dig_q[{idx_q, 2'b00} +: 4];

      an_d   = 4'b1111;
      sseg_d = 7'b1111111;
      dp_d   = 1'b1;
      if (!in_blank && !lz_m[idx_q]) begin
         an_d[idx_q] = 1'b0;
         sseg_d      = dec(cur);
         dp_d        = ~act_dp_q[idx_q];
      end
   end

   // Scan counters, pending/active buffers and registered pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_lz_q  <= 1'b0;
         pend_vld_q <= 1'b0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         act_lz_q   <= 1'b0;
         ack_q      <= 1'b0;
         an_q       <= 4'b1111;
         sseg_q     <= 7'b1111111;
         dp_q       <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         pend_lz_q  <= pend_lz_d;
         pend_vld_q <= pend_vld_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         act_lz_q   <= act_lz_d;
         ack_q      <= ack_d;
         an_q       <= an_d;
         sseg_q     <= sseg_d;
         dp_q       <= dp_d;
      end
   end

   assign an           = an_q;
   assign sseg         = sseg_q;
   assign dp           = dp_q;
   assign bus.busy     = pend_vld_q;
   assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
// Frame length is 32 cycles; pins lag the scan state by one cycle.
module tb_sseg_scan_ctrl;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000;
   localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001;
   localparam logic [6:0] SE = 7'b0000110, SF = 7'b0001110;
   localparam logic [6:0] SX = 7'b1111111;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  dpv;
      logic        lz;
      logic [27:0] segs;
      logic [3:0]  lit;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] sseg;
   logic       dp;
   logic [3:0] an;
   int         cyc = 0;
   int         n_pass = 0;
   int         n_tot = 0;
   int         ack_cnt = 0;
   int         inv_bad = 0;
   bit         mon_en = 1'b0;

   sseg_scan_if bus_if ();

   sseg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if.slave),
      .sseg (sseg),
      .dp   (dp),
      .an   (an)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   always @(posedge clk)
      if (bus_if.load_ack === 1'b1) ack_cnt++;

   always @(negedge clk)
      if (mon_en) begin
         if ($countones(~an) > 1) inv_bad++;
         if (((cyc - 1) % 8) < 2 && an !== 4'b1111) inv_bad++;
      end

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, got, exp);
   endtask

   task automatic wait_cyc(input int n);
      if (cyc > n) chk("sync", 16'(cyc), 16'(n));
      while (cyc < n) @(negedge clk);
   endtask

   function automatic int next_frame();
      return (cyc / 32 + 1) * 32;
   endfunction

   task automatic check_frame(input string nm, input int base,
                              input vec_t v);
      logic [11:0] exp;
      logic [3:0]  a;
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < 8; c++) begin
            wait_cyc(base + 8 * i + c + 1);
            if (c < 2 || !v.lit[i]) begin
               exp = {4'b1111, SX, 1'b1};
            end else begin
               a = 4'b1111;
               a[i] = 1'b0;
               exp = {a, v.segs[7*i +: 7], ~v.dpv[i]};
            end
            chk($sformatf("%s s%0d c%0d", nm, i, c),
                {4'h0, an, sseg, dp}, {4'h0, exp});
         end
   endtask

   task automatic drive(input logic l, input logic [15:0] d,
                        input logic [3:0] p, input logic z);
      bus_if.load      = l;
      bus_if.digits_in = d;
      bus_if.dp_in     = p;
      bus_if.blank_lz  = z;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int f;
      f = next_frame();
      wait_cyc(f + 5);
      drive(1'b1, v.dig, v.dpv, v.lz);
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      chk($sformatf("v%0d busy", k), 16'(bus_if.busy), 16'd1);
      chk($sformatf("v%0d noack", k), 16'(bus_if.load_ack), 16'd0);
      wait_cyc(f + 32);
      chk($sformatf("v%0d ack", k), 16'(bus_if.load_ack), 16'd1);
      chk($sformatf("v%0d idle", k), 16'(bus_if.busy), 16'd0);
      wait_cyc(f + 33);
      chk($sformatf("v%0d ack1", k), 16'(bus_if.load_ack), 16'd0);
      check_frame($sformatf("v%0d", k), f + 32, v);
   endtask

   vec_t tbl[8];
   vec_t vz, v1111, v2222, vbeef;

   initial begin
      int f, a0;
      tbl[0] = '{16'h1234, 4'b0001, 1'b0, {S1, S2, S3, S4}, 4'b1111};
      tbl[1] = '{16'h0050, 4'b0000, 1'b1, {SX, SX, S5, S0}, 4'b0011};
      tbl[2] = '{16'h0000, 4'b0100, 1'b1, {SX, SX, SX, S0}, 4'b0001};
      tbl[3] = '{16'hC9A7, 4'b1111, 1'b1, {SC, S9, SA, S7}, 4'b1111};
      tbl[4] = '{16'h0100, 4'b0000, 1'b1, {SX, S1, S0, S0}, 4'b0111};
      tbl[5] = '{16'h6D8E, 4'b1010, 1'b0, {S6, SD, S8, SE}, 4'b1111};
      tbl[6] = '{16'h0050, 4'b0110, 1'b0, {S0, S0, S5, S0}, 4'b1111};
      tbl[7] = '{16'h0007, 4'b1000, 1'b1, {SX, SX, SX, S7}, 4'b0001};
      vz     = '{16'h0000, 4'b0000, 1'b0, {S0, S0, S0, S0}, 4'b1111};
      v1111  = '{16'h1111, 4'b0000, 1'b0, {S1, S1, S1, S1}, 4'b1111};
      v2222  = '{16'h2222, 4'b0000, 1'b0, {S2, S2, S2, S2}, 4'b1111};
      vbeef  = '{16'hBEEF, 4'b0000, 1'b0, {SB, SE, SE, SF}, 4'b1111};

      drive(1'b0, 16'h0, 4'h0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst pins", {4'h0, an, sseg, dp}, {4'h0, 4'hF, SX, 1'b1});
      chk("rst busy", 16'(bus_if.busy), 16'd0);
      chk("rst ack", 16'(bus_if.load_ack), 16'd0);
      rst_n = 1'b1;
      check_frame("boot", 0, vz);

      for (int k = 0; k < 8; k++) run_vec(k, tbl[k]);

      f = next_frame();
      wait_cyc(f + 5);
      drive(1'b1, 16'hAAAA, 4'hF, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      @(negedge clk);
      drive(1'b1, 16'hBEEF, 4'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      a0 = ack_cnt;
      wait_cyc(f + 32);
      chk("ovr ack", 16'(bus_if.load_ack), 16'd1);
      check_frame("ovr", f + 32, vbeef);
      chk("ovr acks", 16'(ack_cnt - a0), 16'd1);

      f = next_frame();
      wait_cyc(f + 5);
      drive(1'b1, 16'h1111, 4'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      wait_cyc(f + 31);
      drive(1'b1, 16'h2222, 4'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      chk("col ack1", 16'(bus_if.load_ack), 16'd1);
      chk("col busy", 16'(bus_if.busy), 16'd1);
      check_frame("col1", f + 32, v1111);
      chk("col ack2", 16'(bus_if.load_ack), 16'd1);
      chk("col idle", 16'(bus_if.busy), 16'd0);
      check_frame("col2", f + 64, v2222);

      f = next_frame();
      wait_cyc(f + 5);
      drive(1'b1, 16'h9999, 4'hF, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      wait_cyc(f + 12);
      chk("pre rst", {4'h0, an, sseg, dp}, {4'h0, 4'b1101, S2, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst pins", {4'h0, an, sseg, dp}, {4'h0, 4'hF, SX, 1'b1});
      chk("mid rst busy", 16'(bus_if.busy), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a0 = ack_cnt;
      check_frame("post rst", 0, vz);
      check_frame("post rst2", 32, vz);
      chk("post rst acks", 16'(ack_cnt - a0), 16'd0);

      mon_en = 1'b1;
      repeat (32000) begin
         @(negedge clk);
         drive($urandom_range(0, 19) == 0, 16'($urandom),
               4'($urandom), 1'($urandom));
      end
      drive(1'b0, 16'h0, 4'h0, 1'b0);
      @(negedge clk);
      mon_en = 1'b0;
      chk("anode inv", 16'(inv_bad), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexes four hex digits onto the shared active-low 7-segment bus (sseg) and anode enables (an) of the 4-digit display.
- Replaces free-running anode counting with a fixed scan schedule:
  - per-slot blanking interval (anti-ghosting)
  - double-buffered digit load with frame-aligned handoff
  - optional leading-zero suppression
- Sits between the hex-to-decimal datapath (producer) and the display pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; legal when ≥ 2.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; legal when 0 ≤ BLANK_CYC < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe; capture digits_in/dp_in/blank_lz
- digits_in  in  16  digit3=[15:12] … digit0=[3:0], hex values
- dp_in  in  4  decimal point request per digit, 1 = lit
- blank_lz  in  1  1 = suppress leading zeros for this load
- sseg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  4  anode enables, active-low, an[i] drives digit i
- busy  out  1  pending buffer holds data not yet displayed
- load_ack  out  1  one-cycle pulse when pending data becomes active

Behaviour:
- Reset (async, rst_n=0) clears the following state:
  - an=4'b1111, sseg=7'b1111111, dp=1, busy=0, load_ack=0
  - active and pending buffers = 0, blank_lz flags = 0
  - slot counter cnt=0, digit index idx=0
- Scheduler:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0 and idx increments mod 4 (order 0,1,2,3,0…).
  - Phase BLANK while cnt < BLANK_CYC: an=1111, sseg=1111111, dp=1.
  - Phase ON while cnt ≥ BLANK_CYC: an[idx]=0 and all other an bits 1; sseg = decode of active digit idx; dp = ~active_dp[idx].
  - All outputs are registered: pins reflect (cnt, idx) with 1-cycle latency.
  - Exactly one anode is low at any time, or none; never more than one.
- Load / handshake:
  - On load=1: pending ← {digits_in, dp_in, blank_lz}; busy (pend_valid) ← 1.
  - Frame boundary = cycle where cnt==REFRESH_DIV-1 and idx==3.
  - At the frame boundary, if pend_valid: active ← pending, pend_valid ← 0, load_ack=1 on the next cycle for exactly 1 cycle.
  - Load while busy: pending overwritten, latest wins; only one ack for the transfer.
  - Load in the same cycle as the boundary transfer: old pending moves to active; new data is captured into pending; busy stays 1; the new data is acked at the next boundary.
  - The active buffer never changes mid-frame, so there is no tearing.
- Leading-zero suppression (when active blank_lz=1):
  - Digit i is blanked if active digits i..3 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode high for the whole slot; dp_in for a blanked digit is ignored.
- Decode (hex → sseg, bit6=g … bit0=a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-slot: outputs go to their reset values immediately (async). On release, scan restarts at idx 0, cnt 0, phase BLANK if BLANK_CYC > 0.
- BLANK_CYC=0: no blank phase; anodes switch directly, digit to digit.

Test Plan (REFRESH_DIV=8, BLANK_CYC=2):
- Reset: assert rst_n=0 mid-ON phase → same cycle an=1111, sseg=1111111, dp=1, busy=0, load_ack=0. After release, first ON at cnt=2, idx 0, showing 0 (sseg=1000000, an=1110).
- Load 0x1234, dp_in=0001, blank_lz=0 → sequence follows:
  - busy=1 until the frame boundary; load_ack pulses once.
  - Next frame: an 1110 with sseg=0011001 (4) and dp=0; then 1101/0110000 (3); then 1011/0100100 (2); then 0111/1111001 (1).
  - Each digit is on for 6 cycles, with 2 all-off cycles before it.
- Leading zeros: load 0x0050, blank_lz=1 → digits 3 and 2 hold an=1111 for their full slots; digit1 shows 0010010 (5); digit0 shows 1000000 (0). Load 0x0000, blank_lz=1 → only digit 0 is lit, showing 0.
- Overwrite: load 0xAAAA, then load 0xBEEF two cycles later in the same frame → one load_ack; the next frame shows F,E,E,b (0001110, 0000110, 0000110, 0000011); 0xAAAA never appears.
- Boundary collision: load 0x1111, then strobe load 0x2222 exactly on the frame-boundary cycle → 0x1111 becomes active with ack, busy stays 1; 0x2222 becomes active one frame later with a second ack.
- Anode invariant: random loads over 1000 frames → an never has more than one 0 bit; an=1111 during every cnt<2 window.
